// File: rtl/ram_pkg.sv
// Shared definitions for the simple-dual-port RAM and its clear sequencer.
package ram_pkg;

    localparam int unsigned RD_FIRST = 0;
    localparam int unsigned WR_FIRST = 1;

    typedef enum logic {
        IDLE,
        CLEAR
    } ram_state_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ram_clr_seq.sv
// Clear sequencer: sweeps every word to zero after reset or on a clr request.
module ram_clr_seq
    import ram_pkg::*;
#(
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned CLR_ON_RST = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam int unsigned CNT_W = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEPTH - 1);

    ram_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= (CLR_ON_RST != 0) ? CLEAR : IDLE;
            r_cnt   <= '0;
            r_busy  <= (CLR_ON_RST != 0);
        end else begin
            case (r_state)
                IDLE: begin
                    if (clr) begin
                        r_state <= CLEAR;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                CLEAR: begin
                    // busy drops on the same edge that writes the last word
                    if (r_cnt == LP_LAST) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign clr_we   = r_busy;
    assign clr_addr = ADDR_W'(r_cnt);

endmodule

// File: rtl/sync_ram_dp.sv
// Parametrised simple-dual-port synchronous RAM with registered read,
// selectable collision mode, clear sweep and out-of-range flagging.
module sync_ram_dp
    import ram_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned RD_MODE    = 0,
    parameter int unsigned CLR_ON_RST = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] din,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              busy,
    input  logic              clr,
    output logic              addr_err
);

    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_dout;
    logic              r_dout_valid;
    logic              r_addr_err;

    logic              w_busy;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_wr_ok;
    logic              w_rd_ok;
    logic              w_collide;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_din;
    logic [DATA_W-1:0] w_rd_word;

    ram_clr_seq #(
        .ADDR_W     (ADDR_W),
        .DEPTH      (DEPTH),
        .CLR_ON_RST (CLR_ON_RST)
    ) u_clr_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .busy     (w_busy),
        .clr_we   (w_clr_we),
        .clr_addr (w_clr_addr)
    );

    assign w_wr_ok   = ({1'b0, waddr} < LP_DEPTH);
    assign w_rd_ok   = ({1'b0, raddr} < LP_DEPTH);
    assign w_collide = we && w_wr_ok && (waddr == raddr);

    // The sweep owns the write port while busy; port writes are dropped.
    assign w_mem_we   = w_busy ? w_clr_we   : (we && w_wr_ok);
    assign w_mem_addr = w_busy ? w_clr_addr : waddr;
    assign w_mem_din  = w_busy ? '0         : din;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_din;
        end
    end

    assign w_rd_word = ((RD_MODE == WR_FIRST) && w_collide) ? din : r_mem[raddr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_addr_err   <= 1'b0;
        end else begin
            r_dout_valid <= 1'b0;
            r_addr_err   <= 1'b0;
            if (!w_busy) begin
                if (re) begin
                    r_dout_valid <= 1'b1;
                    r_dout       <= w_rd_ok ? w_rd_word : '0;
                end
                r_addr_err <= (we && !w_wr_ok) || (re && !w_rd_ok);
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign addr_err   = r_addr_err;
    assign busy       = w_busy;

endmodule
